// File: rtl/stopwatch_counter_pkg.sv
// Shared types and constants for the stopwatch: FSM state encoding, BCD digit
// limits and the single-digit step rule used by both the counters and the display.
package stopwatch_counter_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    LAP     = 3'd2,
    STOPPED = 3'd3,
    MAXED   = 3'd4
  } sw_state_t;

  localparam logic [3:0] SEC_ONES_MAX = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] MIN_ONES_MAX = 4'd9;
  localparam logic [3:0] MIN_TENS_MAX = 4'd5;

  // Next value of one BCD digit; clear wins over increment.
  function automatic logic [3:0] bcd_step(input logic [3:0] q, input logic inc,
                                          input logic clr, input logic [3:0] limit);
    if (clr) return 4'd0;
    if (inc) return (q == limit) ? 4'd0 : q + 4'd1;
    return q;
  endfunction

endpackage

// File: rtl/stopwatch_counter_if.sv
// Command and display bundle between the stopwatch and whatever drives it.
interface stopwatch_counter_if;
  import stopwatch_counter_pkg::*;

  // Commands are single-cycle active-high pulses sampled on every rising edge;
  // there is no ready: each high cycle is one command, the block never stalls.
  logic       start_stop;
  logic       lap;
  logic       clear;
  logic [3:0] digit3;
  logic [3:0] digit2;
  logic [3:0] digit1;
  logic [3:0] digit0;
  logic       running;
  logic       lap_held;
  logic       at_max;
  sw_state_t  state;

  modport master (
    output start_stop, lap, clear,
    input  digit3, digit2, digit1, digit0, running, lap_held, at_max, state
  );

  modport slave (
    input  start_stop, lap, clear,
    output digit3, digit2, digit1, digit0, running, lap_held, at_max, state
  );

endinterface

// File: rtl/bcd_digit_counter.sv
// One BCD digit stage: counts 0..LIMIT on inc, carry out when wrapping.
module bcd_digit_counter
  import stopwatch_counter_pkg::*;
#(
  parameter logic [3:0] LIMIT = 4'd9
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] q,
  output logic       carry
);

  assign carry = inc && (q == LIMIT);

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      q <= 4'd0;
    end else begin
      q <= bcd_step(q, inc, clr, LIMIT);
    end
  end

endmodule

// File: rtl/stopwatch_counter.sv
// mm:ss stopwatch: prescaler, control FSM, lap snapshot and registered display,
// with the live count held in four chained BCD digit stages.
module stopwatch_counter
  import stopwatch_counter_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic          CLOCK_50,
  input  logic          RESET_N,
  stopwatch_counter_if.slave sw
);

  localparam int unsigned   PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  sw_state_t     state;
  sw_state_t     state_nxt;
  logic [PW-1:0] pre;
  logic          tick;
  logic          live_max;
  logic          tick_max;
  logic          clr_cnt;
  logic          inc0;
  logic          c0, c1, c2;
  logic          m1_carry_unused;
  logic [3:0]    s0, s1, m0, m1;
  logic [15:0]   live_q;
  logic [15:0]   live_d;
  logic [15:0]   snap;
  logic [15:0]   snap_nxt;
  logic [15:0]   disp;
  logic          lap_entry;
  logic          running_q, lap_held_q, at_max_q;

  assign tick     = ((state == RUN) || (state == LAP)) && (pre == PRE_LAST);
  assign live_max = (s0 == SEC_ONES_MAX) && (s1 == SEC_TENS_MAX) &&
                    (m0 == MIN_ONES_MAX) && (m1 == MIN_TENS_MAX);
  assign tick_max = tick && live_max;
  // At 59:59 the tick is swallowed so the count saturates instead of wrapping.
  assign inc0     = tick && !live_max;
  assign clr_cnt  = sw.clear && ((state == STOPPED) || (state == MAXED));

  bcd_digit_counter #(.LIMIT(SEC_ONES_MAX)) u_s0 (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .inc(inc0), .clr(clr_cnt), .q(s0), .carry(c0)
  );
  bcd_digit_counter #(.LIMIT(SEC_TENS_MAX)) u_s1 (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .inc(c0), .clr(clr_cnt), .q(s1), .carry(c1)
  );
  bcd_digit_counter #(.LIMIT(MIN_ONES_MAX)) u_m0 (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .inc(c1), .clr(clr_cnt), .q(m0), .carry(c2)
  );
  bcd_digit_counter #(.LIMIT(MIN_TENS_MAX)) u_m1 (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .inc(c2), .clr(clr_cnt), .q(m1),
    .carry(m1_carry_unused)
  );

  // Preview of the live count after this edge, so the display register is
  // never a cycle behind the counters.
  assign live_q = {m1, m0, s1, s0};
  assign live_d = {bcd_step(m1, c2, clr_cnt, MIN_TENS_MAX),
                   bcd_step(m0, c1, clr_cnt, MIN_ONES_MAX),
                   bcd_step(s1, c0, clr_cnt, SEC_TENS_MAX),
                   bcd_step(s0, inc0, clr_cnt, SEC_ONES_MAX)};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sw.start_stop) state_nxt = RUN;
      RUN: begin
        if (tick_max)           state_nxt = MAXED;
        else if (sw.start_stop) state_nxt = STOPPED;
        else if (sw.lap)        state_nxt = LAP;
      end
      LAP: begin
        if (tick_max)           state_nxt = MAXED;
        else if (sw.start_stop) state_nxt = STOPPED;
        else if (sw.lap)        state_nxt = RUN;
      end
      STOPPED: begin
        if (sw.clear)           state_nxt = IDLE;
        else if (sw.start_stop) state_nxt = RUN;
      end
      MAXED:   if (sw.clear) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign lap_entry = (state == RUN) && (state_nxt == LAP);
  assign snap_nxt  = lap_entry ? live_q : snap;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= IDLE;
      pre        <= '0;
      snap       <= 16'h0000;
      disp       <= 16'h0000;
      running_q  <= 1'b0;
      lap_held_q <= 1'b0;
      at_max_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        RUN, LAP: pre <= tick ? '0 : pre + 1'b1;
        STOPPED:  pre <= pre;
        default:  pre <= '0;
      endcase
      snap       <= snap_nxt;
      disp       <= (state_nxt == LAP) ? snap_nxt : live_d;
      running_q  <= (state_nxt == RUN) || (state_nxt == LAP);
      lap_held_q <= (state_nxt == LAP);
      at_max_q   <= (state_nxt == MAXED);
    end
  end

  assign sw.digit3   = disp[15:12];
  assign sw.digit2   = disp[11:8];
  assign sw.digit1   = disp[7:4];
  assign sw.digit0   = disp[3:0];
  assign sw.running  = running_q;
  assign sw.lap_held = lap_held_q;
  assign sw.at_max   = at_max_q;
  assign sw.state    = state;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Bench for stopwatch_counter: directed vector table, hand sequences for reset
// and saturation, and random commands against a seconds-based reference model.
module tb_stopwatch_counter;
  import stopwatch_counter_pkg::*;

  localparam int TD  = 4;
  localparam int TD2 = 2;

  logic CLOCK_50 = 1'b0;
  logic RESET_N  = 1'b0;

  always #5 CLOCK_50 = ~CLOCK_50;

  stopwatch_counter_if sw();
  stopwatch_counter_if sw2();

  stopwatch_counter #(.TICK_DIV(TD)) u_dut (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .sw(sw)
  );
  stopwatch_counter #(.TICK_DIV(TD2)) u_dut2 (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .sw(sw2)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [21:0] exp_q[$];

  typedef struct {
    bit          rst;
    logic        ss, lp, cl;
    int          wait_n;
    sw_state_t   st;
    logic [15:0] dig;
    logic        run, lh, mx;
    string       name;
  } vec_t;
  vec_t vecs[$];

  // Reference model: the count is kept as plain seconds 0..3599.
  bit        model_on = 0;
  sw_state_t m_st;
  int        m_pre, m_secs, m_snap;

  function automatic logic [15:0] to_bcd(input int s);
    int mm, ss_;
    mm  = s / 60;
    ss_ = s % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss_ / 10), 4'(ss_ % 10)};
  endfunction

  function automatic logic [21:0] exp_word(input sw_state_t st, input logic [15:0] d,
                                           input logic r, input logic l, input logic m);
    return {st, d, r, l, m};
  endfunction

  function automatic logic [21:0] word1();
    return {sw.state, sw.digit3, sw.digit2, sw.digit1, sw.digit0,
            sw.running, sw.lap_held, sw.at_max};
  endfunction

  function automatic logic [21:0] word2();
    return {sw2.state, sw2.digit3, sw2.digit2, sw2.digit1, sw2.digit0,
            sw2.running, sw2.lap_held, sw2.at_max};
  endfunction

  task automatic model_reset();
    m_st = IDLE; m_pre = 0; m_secs = 0; m_snap = 0;
  endtask

  task automatic model_step(input logic ss, input logic lp, input logic cl);
    bit        tk;
    sw_state_t nx;
    int        nsecs;
    tk    = ((m_st == RUN) || (m_st == LAP)) && (m_pre == TD - 1);
    nsecs = (tk && m_secs < 3599) ? m_secs + 1 : m_secs;
    nx    = m_st;
    case (m_st)
      IDLE:    if (ss) nx = RUN;
      RUN: begin
        if (tk && m_secs == 3599) nx = MAXED;
        else if (ss) nx = STOPPED;
        else if (lp) begin nx = LAP; m_snap = m_secs; end
      end
      LAP: begin
        if (tk && m_secs == 3599) nx = MAXED;
        else if (ss) nx = STOPPED;
        else if (lp) nx = RUN;
      end
      STOPPED: begin
        if (cl) begin nx = IDLE; nsecs = 0; end
        else if (ss) nx = RUN;
      end
      MAXED:   if (cl) begin nx = IDLE; nsecs = 0; end
      default: nx = IDLE;
    endcase
    if ((m_st == RUN) || (m_st == LAP)) m_pre = tk ? 0 : m_pre + 1;
    else if (m_st != STOPPED) m_pre = 0;
    m_st   = nx;
    m_secs = nsecs;
    exp_q.push_back(exp_word(nx, (nx == LAP) ? to_bcd(m_snap) : to_bcd(m_secs),
                             (nx == RUN) || (nx == LAP), nx == LAP, nx == MAXED));
  endtask

  // Drivers: inputs change at the falling edge, outputs are read there too.
  task automatic drive(input logic ss, input logic lp, input logic cl);
    sw.start_stop = ss; sw.lap = lp; sw.clear = cl;
    @(posedge CLOCK_50);
    if (model_on) model_step(ss, lp, cl);
    @(negedge CLOCK_50);
    sw.start_stop = 1'b0; sw.lap = 1'b0; sw.clear = 1'b0;
  endtask

  task automatic drive2(input logic ss, input logic lp, input logic cl);
    sw2.start_stop = ss; sw2.lap = lp; sw2.clear = cl;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    sw2.start_stop = 1'b0; sw2.lap = 1'b0; sw2.clear = 1'b0;
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    model_reset();
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    RESET_N = 1'b1;
    @(negedge CLOCK_50);
  endtask

  task automatic score(input string name, input logic [21:0] act);
    logic [21:0] e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: no expected value queued, got %h", name, act);
      return;
    end
    e = exp_q.pop_front();
    if (act !== e) begin
      n_fail++;
      $display("FAIL %s: got state=%0d digits=%h flags=%b, expected state=%0d digits=%h flags=%b",
               name, act[21:19], act[18:3], act[2:0], e[21:19], e[18:3], e[2:0]);
    end
  endtask

  task automatic expect_now(input string name, input logic [21:0] act, input sw_state_t st,
                            input logic [15:0] d, input logic r, input logic l, input logic m);
    exp_q.push_back(exp_word(st, d, r, l, m));
    score(name, act);
  endtask

  task automatic add_vec(input bit rst, input logic ss, input logic lp, input logic cl,
                         input int w, input sw_state_t st, input logic [15:0] dig,
                         input logic run, input logic lh, input logic mx, input string nm);
    vec_t v;
    v.rst = rst; v.ss = ss; v.lp = lp; v.cl = cl; v.wait_n = w;
    v.st = st; v.dig = dig; v.run = run; v.lh = lh; v.mx = mx; v.name = nm;
    vecs.push_back(v);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sw.start_stop = 1'b0;  sw.lap = 1'b0;  sw.clear = 1'b0;
    sw2.start_stop = 1'b0; sw2.lap = 1'b0; sw2.clear = 1'b0;
    model_reset();

    // rst, ss, lp, cl, extra idle cycles, expected state/digits/running/lap_held/at_max
    add_vec(1, 1, 0, 0, 48, RUN,     16'h0012, 1, 0, 0, "run_12");
    add_vec(1, 1, 0, 0, 12, RUN,     16'h0003, 1, 0, 0, "lap_pre");
    add_vec(0, 0, 1, 0,  0, LAP,     16'h0003, 1, 1, 0, "lap_enter");
    add_vec(0, 0, 0, 0, 20, LAP,     16'h0003, 1, 1, 0, "lap_hold");
    add_vec(0, 0, 1, 0,  0, RUN,     16'h0008, 1, 0, 0, "lap_exit");
    add_vec(1, 1, 0, 0,  5, RUN,     16'h0001, 1, 0, 0, "pre_stop");
    add_vec(0, 1, 0, 0, 20, STOPPED, 16'h0001, 0, 0, 0, "stopped_hold");
    add_vec(0, 1, 0, 0,  0, RUN,     16'h0001, 1, 0, 0, "restart");
    add_vec(0, 0, 0, 0,  0, RUN,     16'h0001, 1, 0, 0, "restart_p3");
    add_vec(0, 0, 0, 0,  0, RUN,     16'h0002, 1, 0, 0, "first_tick");
    add_vec(0, 0, 0, 1,  0, RUN,     16'h0002, 1, 0, 0, "clear_in_run");
    add_vec(0, 0, 0, 0,  2, RUN,     16'h0003, 1, 0, 0, "clear_no_effect");
    add_vec(1, 1, 0, 0,  4, RUN,     16'h0001, 1, 0, 0, "pre_multi");
    add_vec(0, 1, 0, 0,  0, STOPPED, 16'h0001, 0, 0, 0, "stop_multi");
    add_vec(0, 1, 1, 1,  0, IDLE,    16'h0000, 0, 0, 0, "multi_clear");
    add_vec(0, 0, 1, 0,  0, IDLE,    16'h0000, 0, 0, 0, "idle_lap_ign");
    add_vec(0, 1, 0, 0, 39, RUN,     16'h0009, 1, 0, 0, "pre_9");
    add_vec(0, 1, 0, 0,  0, STOPPED, 16'h0010, 0, 0, 0, "tick_and_stop");
    add_vec(0, 0, 1, 0,  3, STOPPED, 16'h0010, 0, 0, 0, "stopped_lap_ign");
    add_vec(1, 1, 0, 0,  4, RUN,     16'h0001, 1, 0, 0, "pre_prio");
    add_vec(0, 1, 1, 0,  0, STOPPED, 16'h0001, 0, 0, 0, "ss_over_lap");
    add_vec(1, 1, 0, 0,  4, RUN,     16'h0001, 1, 0, 0, "pre_lap2");
    add_vec(0, 0, 1, 0,  0, LAP,     16'h0001, 1, 1, 0, "lap2_enter");
    add_vec(0, 0, 0, 0,  7, LAP,     16'h0001, 1, 1, 0, "lap2_hold");
    add_vec(0, 1, 0, 0,  0, STOPPED, 16'h0003, 0, 0, 0, "lap_stop_live");

    // Reset state while RESET_N is held low from time zero.
    @(negedge CLOCK_50);
    expect_now("reset_state", word1(), IDLE, 16'h0000, 0, 0, 0);
    expect_now("reset_state2", word2(), IDLE, 16'h0000, 0, 0, 0);
    RESET_N = 1'b1;
    @(negedge CLOCK_50);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) do_reset();
      drive(vecs[i].ss, vecs[i].lp, vecs[i].cl);
      repeat (vecs[i].wait_n) drive(1'b0, 1'b0, 1'b0);
      expect_now(vecs[i].name, word1(), vecs[i].st, vecs[i].dig,
                 vecs[i].run, vecs[i].lh, vecs[i].mx);
    end

    // Asynchronous reset in LAP at 00:07, then no residual progress.
    do_reset();
    drive(1'b1, 1'b0, 1'b0);
    repeat (28) drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    expect_now("lap_at_7", word1(), LAP, 16'h0007, 1, 1, 0);
    RESET_N = 1'b0;
    #1;
    expect_now("async_reset", word1(), IDLE, 16'h0000, 0, 0, 0);
    @(negedge CLOCK_50);
    RESET_N = 1'b1;
    repeat (8) drive(1'b0, 1'b0, 1'b0);
    expect_now("post_reset_idle", word1(), IDLE, 16'h0000, 0, 0, 0);

    // Saturation at 59:59 on the TICK_DIV=2 instance.
    do_reset();
    drive2(1'b1, 1'b0, 1'b0);
    repeat (7198) drive2(1'b0, 1'b0, 1'b0);
    expect_now("preload_5959", word2(), RUN, 16'h5959, 1, 0, 0);
    drive2(1'b0, 1'b0, 1'b0);
    drive2(1'b1, 1'b1, 1'b0);
    expect_now("maxed_on_tick", word2(), MAXED, 16'h5959, 0, 0, 1);
    drive2(1'b1, 1'b0, 1'b0);
    expect_now("maxed_ss_ign", word2(), MAXED, 16'h5959, 0, 0, 1);
    repeat (3) drive2(1'b0, 1'b1, 1'b0);
    expect_now("maxed_hold", word2(), MAXED, 16'h5959, 0, 0, 1);
    drive2(1'b0, 1'b0, 1'b1);
    expect_now("maxed_clear", word2(), IDLE, 16'h0000, 0, 0, 0);
    drive2(1'b1, 1'b0, 1'b0);
    repeat (2) drive2(1'b0, 1'b0, 1'b0);
    expect_now("restart_after_max", word2(), RUN, 16'h0001, 1, 0, 0);

    // Random command stream against the reference model.
    do_reset();
    exp_q.delete();
    model_on = 1;
    for (int i = 0; i < 2000; i++) begin
      logic ss, lp, cl;
      ss = ($urandom_range(0, 99) < 7);
      lp = ($urandom_range(0, 99) < 7);
      cl = ($urandom_range(0, 99) < 4);
      drive(ss, lp, cl);
      score("random", word1());
    end
    model_on = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_counter.md
STOPWATCH_COUNTER -- requirements
Module: stopwatch_counter

Interface
REQ-001 Parameter TICK_DIV, default 50000000: CLOCK_50 cycles per count tick (1 s at 50 MHz); legal range >= 2.
REQ-002 CLOCK_50  in  1  sole clock; all state updates on its rising edge.
REQ-003 RESET_N  in  1  asynchronous, active-low reset.
REQ-004 start_stop  in  1  one-cycle active-high command pulse: start or stop the count.
REQ-005 lap  in  1  one-cycle active-high command pulse: freeze or release the display.
REQ-006 clear  in  1  one-cycle active-high command pulse: zero the count.
REQ-007 digit3, digit2, digit1, digit0  out  4 each  displayed BCD value m1 m0 : s1 s0.
REQ-008 running  out  1  high in states RUN and LAP.
REQ-009 lap_held  out  1  high in state LAP.
REQ-010 at_max  out  1  high in state MAXED.

Function
REQ-011 The FSM SHALL have exactly five states: IDLE, RUN, LAP, STOPPED, MAXED.
REQ-012 Prescaler: counts 0..TICK_DIV-1 in RUN/LAP; holds its value in STOPPED; is zeroed in IDLE and MAXED; tick is high for the one cycle in which the prescaler equals TICK_DIV-1 and the state is RUN or LAP.
REQ-013 Live count on tick: s0 increments 0..9; on s0 = 9 it wraps to 0 and s1 increments 0..5; on s1 = 5 and s0 = 9 s1 wraps and m0 increments 0..9; on m0 = 9 m1 increments 0..5.
REQ-014 Tick at live count 59:59: the count holds at 59:59 (no wrap to 00:00) and the state goes to MAXED.
REQ-015 Digit outputs are registered and reflect the new live count on the cycle after the tick.
REQ-016 In LAP, the digits show the snapshot captured on the lap-entry cycle while the live count keeps advancing; in every other state they show the live count.
REQ-017 IDLE: start_stop -> RUN; lap and clear are ignored.
REQ-018 RUN: start_stop -> STOPPED; lap -> LAP, capturing the snapshot; clear is ignored.
REQ-019 LAP: lap -> RUN, and the display returns to the live count on the next cycle; start_stop -> STOPPED, and the display shows the live count; clear is ignored.
REQ-020 STOPPED: start_stop -> RUN, resuming from the held prescaler value; clear -> IDLE with count 00:00; lap is ignored.
REQ-021 MAXED: clear -> IDLE with count 00:00; start_stop and lap are ignored.
REQ-022 Simultaneous commands: priority is clear > start_stop > lap; lower-priority commands in the same cycle are dropped.
REQ-023 Tick coinciding with start_stop in RUN/LAP: the count increments and the state goes to STOPPED in the same edge.
REQ-024 Tick at 59:59 coinciding with any command: MAXED is entered and the commands are dropped.
REQ-025 Command inputs held high for more than one cycle are treated as one command per asserted cycle; no edge detection is done inside this block.

Reset
REQ-026 On RESET_N low, immediately: state IDLE, prescaler 0, live count and snapshot 00:00, all digits 0, running/lap_held/at_max 0.
REQ-027 Reset asserted mid-count (RUN, LAP or MAXED) SHALL discard all progress with no residual tick.
REQ-028 Release of RESET_N SHALL require no further command to reach the IDLE state.

Structure
REQ-029 Shared package SHALL hold: the state encoding (IDLE, RUN, LAP, STOPPED, MAXED) and the BCD limit constants SEC_ONES_MAX = 9, SEC_TENS_MAX = 5, MIN_ONES_MAX = 9, MIN_TENS_MAX = 5.
REQ-030 The four digit stages SHALL use one sub-module, bcd_digit_counter (parameter LIMIT; inputs inc, clr; outputs q[3:0], carry = inc and q == LIMIT), instantiated four times.
REQ-031 The prescaler, FSM, snapshot register and output muxing SHALL live in stopwatch_counter.

Verification (TICK_DIV = 4 unless stated)
REQ-032 Reset, then start_stop, then 12 ticks (48 cycles) -> digits 00:12, running = 1.
REQ-033 Lap at count 00:03, run 5 more ticks -> digits stay 00:03 with lap_held = 1; lap again -> digits show 00:08 on the next cycle.
REQ-034 Stop at prescaler value 2, wait 20 cycles, start_stop -> first tick arrives 2 cycles after restart; clear while in RUN -> count is unchanged.
REQ-035 Preload through 3599 ticks with TICK_DIV = 2 -> 59:59; one more tick -> digits 59:59, at_max = 1; start_stop is ignored; clear -> 00:00 in IDLE.
REQ-036 clear, start_stop and lap asserted in the same cycle while STOPPED -> IDLE with 00:00; tick and start_stop in the same cycle at 00:09 -> 00:10 in STOPPED.
REQ-037 RESET_N pulsed low in LAP at 00:07 -> all outputs are zero before the next clock edge.
